// File: rtl/synth_pkg.sv
// Shared widths, FSM encoding and harmonic weighting for the additive voice.
package synth_pkg;
   localparam int N_HARM      = 4;
   localparam int STEP_INT_W  = 10;
   localparam int STEP_FRAC_W = 10;
   localparam int STEP_W      = STEP_INT_W + STEP_FRAC_W;
   localparam int PHASE_W     = 20;
   localparam int SINE_ADDR_W = 10;
   localparam int SINE_W      = 16;
   localparam int ACC_W       = 18;
   localparam int NOTE_W      = 6;
   localparam int HARM_IDX_W  = 2;
   localparam logic [HARM_IDX_W-1:0] LAST_HARM = HARM_IDX_W'(N_HARM - 1);

   // Harmonic h is attenuated by 2^-h.
   localparam int WEIGHT_SHIFT [N_HARM] = '{0, 1, 2, 3};

   typedef enum logic [2:0] {
      IDLE,
      LOAD_ADDR,
      LOAD_WAIT,
      RUN,
      DONE
   } state_t;

   function automatic logic signed [ACC_W-1:0] harm_term(
      input logic signed [SINE_W-1:0] s,
      input logic [HARM_IDX_W-1:0]    h
   );
      logic signed [ACC_W-1:0] ext;
      ext = ACC_W'(s);
      return ext >>> WEIGHT_SHIFT[h];
   endfunction
endpackage

// File: rtl/harmonic_phase_bank.sv
// Per-harmonic step and phase registers; one phase advances per cycle on request.
module harmonic_phase_bank
   import synth_pkg::*;
(
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     load,
   input  logic [N_HARM*STEP_W-1:0]                 steps_in,
   input  logic                                     advance,
   input  logic [HARM_IDX_W-1:0]                    harm,
   input  logic                                     clear,
   output logic [N_HARM-1:0][STEP_W-1:0]            step,
   output logic [N_HARM-1:0][SINE_ADDR_W-1:0]       phase_idx
);
   for (genvar gi = 0; gi < N_HARM; gi++) begin : g_harm
      logic [STEP_W-1:0]  step_reg;
      logic [PHASE_W-1:0] phase_reg;

      // Harmonic 0 sits in the most significant word of the ROM line.
      always_ff @(posedge clk) begin
         if (reset) begin
            step_reg  <= '0;
            phase_reg <= '0;
         end else begin
            if (load)
               step_reg <= steps_in[(N_HARM-1-gi)*STEP_W +: STEP_W];
            if (clear)
               phase_reg <= '0;
            else if (advance && harm == HARM_IDX_W'(gi))
               phase_reg <= phase_reg + step_reg;
         end
      end

      assign step[gi]      = step_reg;
      assign phase_idx[gi] = phase_reg[PHASE_W-1 -: SINE_ADDR_W];
   end
endmodule

// File: rtl/harmonic_voice.sv
// Four-harmonic additive voice: note step fetch, sequential sine lookups, weighted sum.
module harmonic_voice
   import synth_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NOTE_W-1:0]        note,
   input  logic                     note_load,
   output logic [NOTE_W-1:0]        rom_addr,
   input  logic [N_HARM*STEP_W-1:0] rom_dout,
   output logic [SINE_ADDR_W-1:0]   sine_addr,
   input  logic [SINE_W-1:0]        sine_dout,
   input  logic                     sample_req,
   output logic [SINE_W-1:0]        sample,
   output logic                     sample_valid,
   output logic                     overrun
);
   state_t state_reg, state_next;

   logic [NOTE_W-1:0]          cur_note_reg, pend_note_reg, rom_addr_reg;
   logic                       load_pend_reg, req_pend_reg, overrun_reg, sample_valid_reg;
   logic [SINE_ADDR_W-1:0]     sine_addr_reg;
   logic [SINE_W-1:0]          sample_reg;
   logic signed [ACC_W-1:0]    acc_reg;
   logic [HARM_IDX_W-1:0]      harm_reg, term_harm;

   logic take_load, take_req, bank_load, bank_clear, advance;
   logic signed [ACC_W-1:0] term, total;
   logic [NOTE_W-1:0] load_note;

   logic [N_HARM-1:0][STEP_W-1:0]      bank_step;
   logic [N_HARM-1:0][SINE_ADDR_W-1:0] bank_phase_idx;

   harmonic_phase_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .load      (bank_load),
      .steps_in  (rom_dout),
      .advance   (advance),
      .harm      (harm_reg),
      .clear     (bank_clear),
      .step      (bank_step),
      .phase_idx (bank_phase_idx)
   );

   assign load_note = note_load ? note : pend_note_reg;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (take_load) state_next = LOAD_ADDR;
                    else if (take_req) state_next = RUN;
         LOAD_ADDR: state_next = LOAD_WAIT;
         LOAD_WAIT: state_next = IDLE;
         RUN:       if (harm_reg == LAST_HARM) state_next = DONE;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Sine data arriving now belongs to the harmonic addressed one cycle earlier.
   always_comb begin
      take_load  = 1'b0;
      take_req   = 1'b0;
      bank_load  = 1'b0;
      bank_clear = 1'b0;
      advance    = 1'b0;
      term_harm  = harm_reg - 2'd1;
      term       = harm_term(sine_dout, term_harm);
      if (bank_step[term_harm] == '0) term = '0;
      total      = acc_reg + term;
      case (state_reg)
         IDLE: begin
            take_load = load_pend_reg | note_load;
            take_req  = !take_load && (req_pend_reg | sample_req);
         end
         LOAD_WAIT: begin
            bank_load  = 1'b1;
            bank_clear = (cur_note_reg == '0);
         end
         RUN:     advance = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_note_reg     <= '0;
         pend_note_reg    <= '0;
         rom_addr_reg     <= '0;
         load_pend_reg    <= 1'b0;
         req_pend_reg     <= 1'b0;
         overrun_reg      <= 1'b0;
         sample_valid_reg <= 1'b0;
         sine_addr_reg    <= '0;
         sample_reg       <= '0;
         acc_reg          <= '0;
         harm_reg         <= '0;
      end else begin
         sample_valid_reg <= 1'b0;

         if (take_load) load_pend_reg <= 1'b0;
         else if (note_load) begin
            load_pend_reg <= 1'b1;
            pend_note_reg <= note;
         end

         // A request arriving while one is already queued is lost.
         if (take_req) req_pend_reg <= req_pend_reg & sample_req;
         else if (sample_req) begin
            if (req_pend_reg) overrun_reg <= 1'b1;
            req_pend_reg <= 1'b1;
         end

         if (take_load) begin
            rom_addr_reg <= load_note;
            cur_note_reg <= load_note;
         end

         if (take_req) begin
            sine_addr_reg <= bank_phase_idx[0];
            acc_reg       <= '0;
            harm_reg      <= '0;
         end

         if (state_reg == RUN) begin
            harm_reg <= harm_reg + 2'd1;
            if (harm_reg != LAST_HARM) sine_addr_reg <= bank_phase_idx[harm_reg + 2'd1];
            if (harm_reg != '0) acc_reg <= total;
         end

         if (state_reg == DONE) begin
            sample_reg       <= (cur_note_reg == '0) ? '0 : SINE_W'(total >>> 1);
            sample_valid_reg <= 1'b1;
         end
      end
   end

   assign rom_addr     = rom_addr_reg;
   assign sine_addr    = sine_addr_reg;
   assign sample       = sample_reg;
   assign sample_valid = sample_valid_reg;
   assign overrun      = overrun_reg;
endmodule

// File: doc/harmonic_voice.md
# harmonic_voice

Single-voice additive synthesizer. Reads the four harmonic step sizes for a note from `harmonics_rom` and runs one 20-bit phase accumulator per harmonic. On each sample request it reads the shared 1024-entry sine ROM once per harmonic, sums the weighted results, and emits one signed 16-bit sample. It sits between the note sequencer (which drives `note`/`note_load`) and the codec sample interface (which drives `sample_req`).

## Interface
- `N_HARM`, 4: number of harmonics. Fixed by the ROM word layout of 4 × 20 bits.
- `SINE_W`, 16: sine ROM data width, signed.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `note` in 6: note index. 0 = rest.
- `note_load` in 1: one-cycle pulse; latch `note` and fetch its steps.
- `rom_addr` out 6: registered address to `harmonics_rom`. ROM has 1-cycle registered latency.
- `rom_dout` in 80: {h0_int, h0_frac, h1_int, h1_frac, h2_int, h2_frac, h3_int, h3_frac}, 10 bits each.
- `sine_addr` out 10: registered address to the sine ROM. ROM has 1-cycle registered latency.
- `sine_dout` in 16: signed sine sample.
- `sample_req` in 1: one-cycle pulse requesting the next sample.
- `sample` out 16: signed output sample; holds until the next update.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `overrun` out 1: sticky; set when a `sample_req` is dropped. Cleared only by `reset`.

## Operation
- **State:** step[h] (20 bits, 10.10 fixed point), phase[h] (20 bits), cur_note (6 bits), load_pend flag, req_pend flag, accumulator acc (18 bits signed).
- **FSM states:** IDLE, LOAD_ADDR, LOAD_WAIT, RUN, DONE.
- **IDLE arbitration:**
  - load_pend (or `note_load`) takes priority over req_pend (or `sample_req`).
  - Load path: `rom_addr <= note`, cur_note <= note, then → LOAD_ADDR.
  - Sample path: `sine_addr <= phase[0][19:10]`, acc <= 0, h <= 0, then → RUN.
- **Load path:**
  - LOAD_ADDR → LOAD_WAIT.
  - In LOAD_WAIT, latch step[h] from `rom_dout`, then → IDLE.
  - If cur_note == 0: also clear all phase[h] to 0.
  - Non-rest loads keep existing phases; no phase reset, to avoid clicks.
- **RUN, one cycle per harmonic h = 0..3:**
  - Advance: phase[h] <= phase[h] + step[h], modulo 2^20.
  - Issue the next address: `sine_addr <= phase[h+1][19:10]`.
  - From the second RUN cycle on, sine data for harmonic h−1 is valid. Add term(h−1) = step[h−1] == 0 ? 0 : sext(`sine_dout`) >>> (h−1).
  - The final term (h = 3) is added in DONE.
- **DONE:**
  - `sample <= (acc + term3)[16:1]`, i.e. total >>> 1.
  - `sample_valid <= 1` for the next cycle.
  - → IDLE.
- **Arithmetic:** worst-case |sum| = 32767 × 1.875 < 2^16, so the 18-bit acc cannot overflow. The >>>1 guarantees 16-bit range; no saturation logic.
- **Rest:** when cur_note == 0, DONE forces `sample <= 0`. `sample_valid` still pulses.
- **Pending events:**
  - `note_load` in a non-IDLE state sets load_pend. It captures `note` into a pending register; the last load wins.
  - `sample_req` in a non-IDLE state sets req_pend.
  - `sample_req` while req_pend is already set is dropped and sets `overrun`.
- **Reset values:** all outputs 0 (`rom_addr`, `sine_addr`, `sample`, `sample_valid`, `overrun`); all internal state 0; FSM in IDLE. Reset mid-RUN or mid-LOAD abandons the operation with no `sample_valid` pulse.

## Timing
- **Sample latency:** `sample_req` high in cycle T (FSM in IDLE)
  - `sine_addr` = phase[0..3] in cycles T+1..T+4.
  - `sine_dout` valid in T+2..T+5.
  - `sample_valid` high in T+6.
  - Busy for 6 cycles; back in IDLE at T+6.
- **Load latency:** `note_load` in T (IDLE)
  - `rom_addr` = note in T+1.
  - `rom_dout` valid in T+2.
  - New steps take effect from T+3.
  - A sample requested in T+1..T+2 uses the new steps.
- **Phase update:** each phase advances exactly once per emitted sample.

## Structure
- **Package `synth_pkg`:**
  - Widths: STEP_INT_W = 10, STEP_FRAC_W = 10, PHASE_W = 20, SINE_ADDR_W = 10, ACC_W = 18.
  - N_HARM.
  - FSM state enum.
  - Harmonic weight shifts {0, 1, 2, 3}.
- **Sub-module `harmonic_phase_bank`:** step/phase registers with load, advance(h) and clear ports.

## Test plan
- **Reset then idle `sample_req`:** `sample_valid` pulses at T+6 with `sample` = 0. `rom_addr`, `sine_addr` and `overrun` stay 0.
- **Load note 37 (4A):** `rom_addr` = 37 at T+1. Steps latch to {75.95, 150.191, 225.286, 300.382}. The first sample reads `sine_addr` 0,0,0,0. The second reads 75,150,225,300.
- **Note 61, 1000 samples vs. golden model:** h3 step = 0, so h3 contributes nothing. Outputs match a model with bit-exact phase wrap (phase[0] crosses 2^20).
- **`note_load` and `sample_req` in the same IDLE cycle:** load runs first (3 cycles), then the sample uses the new steps. `sample_valid` arrives at T+9.
- **Two extra `sample_req` during RUN:** the first is serviced right after DONE. The second sets `overrun` = 1, which stays high until `reset`.
- **Load note 0 after note 37:** phases clear to 0 and `sample` = 0. Reload note 37: the first `sine_addr` sequence is 0,0,0,0. Also assert `reset` mid-RUN: no `sample_valid` pulse, and all outputs return to 0.
